// File: rtl/pll_supervisor.sv
// PLL start-up supervisor: pulses the PLL reset, filters lock, then staggers domain reset releases.
// Optional retry limit with a terminal FAULT state when PLL_SUPERVISOR_RETRY_LIMIT_EN is defined.
module pll_supervisor #(
  parameter int NUM_DOMAINS        = 3,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int LOCK_FILTER_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 100,
  parameter int RELEASE_GAP        = 4,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                   input_clk,
  input  logic                   reset_n,
  input  logic                   locked,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             lost_count,
  output logic                   fault
);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, FILTER, RELEASE, RUN, FAULT} state_e;

  // One shared timer serves every state, so size it for the sum of all limits.
  localparam int TMAX     = PLL_RST_CYCLES + TIMEOUT_CYCLES + LOCK_FILTER_CYCLES + NUM_DOMAINS * RELEASE_GAP;
  localparam int TW       = $clog2(TMAX + 1);
  localparam int LAST_GAP = (NUM_DOMAINS - 1) * RELEASE_GAP;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   locked_meta_q, locked_s_q;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lost_count_q, lost_count_d;
  logic                   fault_q, fault_d;
  logic                   retry_exhausted;
  logic                   timeout_fire;

  always_ff @(posedge input_clk) begin
    if (!reset_n) begin
      state_q       <= RESET_PLL;
      timer_q       <= '0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_reset_q   <= 1'b1;
      dom_q         <= '0;
      ready_q       <= 1'b0;
      lost_count_q  <= 8'd0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
      pll_reset_q   <= pll_reset_d;
      dom_q         <= dom_d;
      ready_q       <= ready_d;
      lost_count_q  <= lost_count_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    lost_count_d = lost_count_q;
    timeout_fire = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (timer_q == TW'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = FILTER;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_fire = 1'b1;
          timer_d      = '0;
          state_d      = retry_exhausted ? FAULT : RESET_PLL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FILTER: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_FILTER_CYCLES - 1)) begin
          state_d = (NUM_DOMAINS == 1) ? RUN : RELEASE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE, RUN: begin
        // Lock loss restarts the PLL but is not counted as a retry.
        if (!locked_s_q) begin
          state_d = RESET_PLL;
          timer_d = '0;
          if (lost_count_q != 8'hFF) lost_count_d = lost_count_q + 8'd1;
        end else if (state_q == RELEASE) begin
          if (timer_q == TW'(LAST_GAP - 1)) begin
            state_d = RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RESET_PLL;
    endcase
  end

  always_comb begin
    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
    ready_d     = (state_d == RUN);
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    fault_d     = (state_d == FAULT);
`else
    fault_d     = 1'b0;
`endif
  end

  // Domain k releases once k*RELEASE_GAP cycles have elapsed since RELEASE entry.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
    assign dom_d[gi] = (state_d == RUN) ||
                       ((state_d == RELEASE) && (timer_d >= TW'(gi * RELEASE_GAP)));
  end

`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retry_q, retry_d;

  assign retry_exhausted = (retry_q == RW'(MAX_RETRIES));

  always_comb begin
    retry_d = retry_q;
    if (timeout_fire && !retry_exhausted) retry_d = retry_q + RW'(1);
  end

  always_ff @(posedge input_clk) begin
    if (!reset_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
`else
  logic unused_retry;
  assign retry_exhausted = 1'b0;
  assign unused_retry    = timeout_fire & (MAX_RETRIES != 0);
`endif

  assign pll_reset    = pll_reset_q;
  assign domain_rst_n = dom_q;
  assign ready        = ready_q;
  assign lost_count   = lost_count_q;
  assign fault        = fault_q;

endmodule
